// File: rtl/pic_host_interface_pkg.sv
// Shared encodings for the 8259A host-side bus initiator: command kinds,
// sequencer/bus states and the OCW2/OCW3 discriminator bits.
package pic_pkg;

  localparam logic [2:0] CMD_ICW1 = 3'd0;
  localparam logic [2:0] CMD_ICW2 = 3'd1;
  localparam logic [2:0] CMD_ICW3 = 3'd2;
  localparam logic [2:0] CMD_ICW4 = 3'd3;
  localparam logic [2:0] CMD_OCW1 = 3'd4;
  localparam logic [2:0] CMD_OCW2 = 3'd5;
  localparam logic [2:0] CMD_OCW3 = 3'd6;
  localparam logic [2:0] CMD_READ = 3'd7;

  // Value required in cmd_data[4:3] to distinguish OCW2/OCW3 from ICW1
  localparam logic [1:0] OCW2_TAG = 2'b00;
  localparam logic [1:0] OCW3_TAG = 2'b01;

  typedef enum logic [2:0] {
    SEQ_UNINIT    = 3'd0,
    SEQ_WAIT_ICW2 = 3'd1,
    SEQ_WAIT_ICW3 = 3'd2,
    SEQ_WAIT_ICW4 = 3'd3,
    SEQ_READY     = 3'd4
  } seq_state_t;

  typedef enum logic [1:0] {
    BUS_IDLE   = 2'd0,
    BUS_SETUP  = 2'd1,
    BUS_STROBE = 2'd2,
    BUS_HOLD   = 2'd3
  } bus_state_t;

endpackage

// File: rtl/pic_host_interface_if.sv
// Host-side command/response channel of the PIC bus initiator.
interface pic_host_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_kind;
  logic [7:0] cmd_data;
  logic       cmd_error;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       init_done;

  modport master (
    output cmd_valid, cmd_kind, cmd_data,
    input  cmd_ready, cmd_error, rsp_valid, rsp_data, init_done
  );

  modport slave (
    input  cmd_valid, cmd_kind, cmd_data,
    output cmd_ready, cmd_error, rsp_valid, rsp_data, init_done
  );
endinterface

// File: rtl/pic_host_interface_init_tracker.sv
// ICW initialization sequencer: decides command legality and the A0 value,
// and advances the sequence at command acceptance.
module pic_init_tracker
  import pic_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       accept,
  input  logic [2:0] kind,
  input  logic [1:0] tag,
  input  logic       sngl,
  input  logic       lsb,
  output logic       legal,
  output logic       a0,
  output logic       init_done
);

  seq_state_t seq;
  logic       ic4_q;
  logic       sngl_q;

  always_comb begin
    legal = 1'b0;
    unique case (kind)
      CMD_ICW1: legal = tag[1];
      CMD_ICW2: legal = (seq == SEQ_WAIT_ICW2);
      CMD_ICW3: legal = (seq == SEQ_WAIT_ICW3);
      CMD_ICW4: legal = (seq == SEQ_WAIT_ICW4);
      CMD_OCW1: legal = (seq == SEQ_READY);
      CMD_OCW2: legal = (seq == SEQ_READY) && (tag == OCW2_TAG);
      CMD_OCW3: legal = (seq == SEQ_READY) && (tag == OCW3_TAG);
      default:  legal = (seq == SEQ_READY);
    endcase
  end

  always_comb begin
    a0 = 1'b1;
    if (kind == CMD_ICW1 || kind == CMD_OCW2 || kind == CMD_OCW3) a0 = 1'b0;
    else if (kind == CMD_READ) a0 = lsb;
  end

  assign init_done = (seq == SEQ_READY);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq    <= SEQ_UNINIT;
      ic4_q  <= 1'b0;
      sngl_q <= 1'b0;
    end else if (accept && legal) begin
      unique case (kind)
        CMD_ICW1: begin
          seq    <= SEQ_WAIT_ICW2;
          ic4_q  <= lsb;
          sngl_q <= sngl;
        end
        CMD_ICW2: seq <= !sngl_q ? SEQ_WAIT_ICW3 : (ic4_q ? SEQ_WAIT_ICW4 : SEQ_READY);
        CMD_ICW3: seq <= ic4_q ? SEQ_WAIT_ICW4 : SEQ_READY;
        CMD_ICW4: seq <= SEQ_READY;
        default:  seq <= seq;
      endcase
    end
  end

endmodule

// File: rtl/pic_host_interface.sv
// CPU-side bus initiator for the 8259A: runs timed SETUP/STROBE/HOLD bus
// cycles with registered pins and returns read data to the host.
module pic_host_interface
  import pic_pkg::*;
#(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic       clk,
  input  logic       reset,
  pic_host_if.slave  host,
  output logic       chip_select_bar,
  output logic       write_bar,
  output logic       read_bar,
  output logic       A0,
  output logic [7:0] data_bus_out,
  output logic       data_bus_oe,
  input  logic [7:0] data_bus_in
);

  localparam int MAX_SH = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int MAX_P  = (STROBE_CYCLES > MAX_SH) ? STROBE_CYCLES : MAX_SH;
  localparam int CNT_W  = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  bus_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             is_read;
  logic             accept;
  logic             legal;
  logic             a0_dec;
  logic             phase_last;
  logic             cmd_error_q;
  logic             rsp_valid_q;
  logic [7:0]       rsp_data_q;

  assign host.cmd_ready = (state == BUS_IDLE);
  assign host.cmd_error = cmd_error_q;
  assign host.rsp_valid = rsp_valid_q;
  assign host.rsp_data  = rsp_data_q;
  assign accept         = host.cmd_valid && host.cmd_ready;
  assign phase_last     = (cnt == '0);

  pic_init_tracker u_tracker (
    .clk       (clk),
    .reset     (reset),
    .accept    (accept),
    .kind      (host.cmd_kind),
    .tag       (host.cmd_data[4:3]),
    .sngl      (host.cmd_data[1]),
    .lsb       (host.cmd_data[0]),
    .legal     (legal),
    .a0        (a0_dec),
    .init_done (host.init_done)
  );

  // Counters hold (phase length - 1) and reload on every phase entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= BUS_IDLE;
      cnt             <= '0;
      is_read         <= 1'b0;
      chip_select_bar <= 1'b1;
      write_bar       <= 1'b1;
      read_bar        <= 1'b1;
      A0              <= 1'b0;
      data_bus_out    <= 8'h00;
      data_bus_oe     <= 1'b0;
      cmd_error_q     <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_data_q      <= 8'h00;
    end else begin
      cmd_error_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      unique case (state)
        BUS_IDLE: begin
          if (accept) begin
            if (legal) begin
              state           <= BUS_SETUP;
              cnt             <= CNT_W'(SETUP_CYCLES - 1);
              chip_select_bar <= 1'b0;
              A0              <= a0_dec;
              is_read         <= (host.cmd_kind == CMD_READ);
              data_bus_oe     <= (host.cmd_kind != CMD_READ);
              if (host.cmd_kind != CMD_READ) data_bus_out <= host.cmd_data;
            end else begin
              cmd_error_q <= 1'b1;
            end
          end
        end
        BUS_SETUP: begin
          if (phase_last) begin
            state <= BUS_STROBE;
            cnt   <= CNT_W'(STROBE_CYCLES - 1);
            if (is_read) read_bar <= 1'b0;
            else         write_bar <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        BUS_STROBE: begin
          if (phase_last) begin
            state     <= BUS_HOLD;
            cnt       <= CNT_W'(HOLD_CYCLES - 1);
            write_bar <= 1'b1;
            read_bar  <= 1'b1;
            if (is_read) begin
              rsp_data_q  <= data_bus_in;
              rsp_valid_q <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          if (phase_last) begin
            state           <= BUS_IDLE;
            chip_select_bar <= 1'b1;
            data_bus_oe     <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pic_host_interface.sv
// Directed self-checking bench for pic_host_interface with default 1/2/1 timing.
module tb_pic_host_interface;
  import pic_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       chip_select_bar, write_bar, read_bar, A0, data_bus_oe;
  logic [7:0] data_bus_out;
  logic [7:0] din;
  int         checks = 0;
  int         failures = 0;

  logic       cap_cs[1:6], cap_wr[1:6], cap_rd[1:6], cap_a0[1:6], cap_oe[1:6];
  logic       cap_err[1:6], cap_rdy[1:6], cap_rv[1:6], cap_init[1:6];
  logic [7:0] cap_dbo[1:6], cap_rsp[1:6];

  pic_host_if hif ();

  pic_host_interface dut (
    .clk             (clk),
    .reset           (reset),
    .host            (hif),
    .chip_select_bar (chip_select_bar),
    .write_bar       (write_bar),
    .read_bar        (read_bar),
    .A0              (A0),
    .data_bus_out    (data_bus_out),
    .data_bus_oe     (data_bus_oe),
    .data_bus_in     (din)
  );

  always #5 clk = ~clk;

  // Issue one command (called #1 after an edge) and record cycles E0+1..E0+6
  task automatic run_cmd(input logic [2:0] k, input logic [7:0] d);
    hif.cmd_kind  = k;
    hif.cmd_data  = d;
    hif.cmd_valid = 1'b1;
    @(posedge clk); #1;
    hif.cmd_valid = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      cap_cs[i] = chip_select_bar;  cap_wr[i] = write_bar;  cap_rd[i] = read_bar;
      cap_a0[i] = A0;               cap_oe[i] = data_bus_oe; cap_dbo[i] = data_bus_out;
      cap_err[i] = hif.cmd_error;   cap_rdy[i] = hif.cmd_ready;
      cap_rv[i] = hif.rsp_valid;    cap_rsp[i] = hif.rsp_data;
      cap_init[i] = hif.init_done;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    hif.cmd_valid = 1'b0; hif.cmd_kind = 3'd0; hif.cmd_data = 8'h00; din = 8'h00;
    #3;
    if ({chip_select_bar, write_bar, read_bar, A0, data_bus_oe} !== 5'b11100) begin
      failures++; $display("FAIL reset_pins got %b want 11100", {chip_select_bar, write_bar, read_bar, A0, data_bus_oe});
    end
    checks++;
    if (data_bus_out !== 8'h00) begin failures++; $display("FAIL reset_dbo got %h want 00", data_bus_out); end
    checks++;
    if ({hif.cmd_ready, hif.cmd_error, hif.rsp_valid, hif.init_done} !== 4'b1000) begin
      failures++; $display("FAIL reset_host got %b want 1000", {hif.cmd_ready, hif.cmd_error, hif.rsp_valid, hif.init_done});
    end
    checks++;
    if (hif.rsp_data !== 8'h00) begin failures++; $display("FAIL reset_rsp got %h want 00", hif.rsp_data); end
    checks++;
    @(posedge clk); #1; reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_init_sequence();
    logic [2:0] ks[4];
    logic [7:0] ds[4];
    logic       a0s[4];
    ks = '{CMD_ICW1, CMD_ICW2, CMD_ICW3, CMD_ICW4};
    ds = '{8'h11, 8'h20, 8'h00, 8'h01};
    a0s = '{1'b0, 1'b1, 1'b1, 1'b1};
    for (int n = 0; n < 4; n++) begin
      run_cmd(ks[n], ds[n]);
      for (int c = 1; c <= 5; c++) begin
        if (cap_cs[c] !== ((c <= 4) ? 1'b0 : 1'b1)) begin
          failures++; $display("FAIL init_cs cmd%0d cyc%0d got %b", n, c, cap_cs[c]);
        end
        checks++;
        if (cap_wr[c] !== ((c == 2 || c == 3) ? 1'b0 : 1'b1)) begin
          failures++; $display("FAIL init_wr cmd%0d cyc%0d got %b", n, c, cap_wr[c]);
        end
        checks++;
        if (cap_rd[c] !== 1'b1) begin failures++; $display("FAIL init_rd cmd%0d cyc%0d got %b want 1", n, c, cap_rd[c]); end
        checks++;
        if (cap_rdy[c] !== ((c <= 4) ? 1'b0 : 1'b1)) begin
          failures++; $display("FAIL init_ready cmd%0d cyc%0d got %b", n, c, cap_rdy[c]);
        end
        checks++;
        if (c <= 4) begin
          if (cap_a0[c] !== a0s[n]) begin failures++; $display("FAIL init_a0 cmd%0d cyc%0d got %b want %b", n, c, cap_a0[c], a0s[n]); end
          checks++;
          if (cap_dbo[c] !== ds[n] || cap_oe[c] !== 1'b1) begin
            failures++; $display("FAIL init_data cmd%0d cyc%0d got %h/%b want %h/1", n, c, cap_dbo[c], cap_oe[c], ds[n]);
          end
          checks++;
        end
      end
      if (cap_init[1] !== (n == 3)) begin failures++; $display("FAIL init_done cmd%0d got %b want %b", n, cap_init[1], (n == 3)); end
      checks++;
      if (cap_err[1] !== 1'b0) begin failures++; $display("FAIL init_err cmd%0d got 1 want 0", n); end
      checks++;
    end
  endtask

  task automatic test_sngl_skip();
    run_cmd(CMD_ICW1, 8'h13);
    if (cap_init[1] !== 1'b0) begin failures++; $display("FAIL sngl_icw1_initdone got %b want 0", cap_init[1]); end
    checks++;
    run_cmd(CMD_ICW2, 8'h08);
    if (cap_cs[1] !== 1'b0 || cap_a0[1] !== 1'b1) begin failures++; $display("FAIL sngl_icw2 got cs=%b a0=%b want 0/1", cap_cs[1], cap_a0[1]); end
    checks++;
    run_cmd(CMD_ICW3, 8'h00);
    if (cap_err[1] !== 1'b1 || cap_err[2] !== 1'b0) begin
      failures++; $display("FAIL sngl_icw3_err got %b%b want 10", cap_err[1], cap_err[2]);
    end
    checks++;
    for (int c = 1; c <= 6; c++) begin
      if (cap_cs[c] !== 1'b1 || cap_wr[c] !== 1'b1 || cap_rdy[c] !== 1'b1) begin
        failures++; $display("FAIL sngl_icw3_bus cyc%0d got cs=%b wr=%b rdy=%b want 1/1/1", c, cap_cs[c], cap_wr[c], cap_rdy[c]);
      end
      checks++;
    end
    run_cmd(CMD_ICW4, 8'h01);
    if (cap_err[1] !== 1'b0 || cap_wr[2] !== 1'b0 || cap_init[1] !== 1'b1) begin
      failures++; $display("FAIL sngl_icw4 got err=%b wr=%b init=%b want 0/0/1", cap_err[1], cap_wr[2], cap_init[1]);
    end
    checks++;
  endtask

  task automatic test_ocw1_gating();
    reset = 1'b1; @(posedge clk); #1; reset = 1'b0; @(posedge clk); #1;
    run_cmd(CMD_OCW1, 8'hFB);
    if (cap_err[1] !== 1'b1) begin failures++; $display("FAIL pre_ocw1_err got %b want 1", cap_err[1]); end
    checks++;
    for (int c = 1; c <= 6; c++) begin
      if (cap_cs[c] !== 1'b1) begin failures++; $display("FAIL pre_ocw1_cs cyc%0d got %b want 1", c, cap_cs[c]); end
      checks++;
    end
    run_cmd(CMD_ICW1, 8'h12);
    run_cmd(CMD_ICW2, 8'h08);
    if (cap_init[1] !== 1'b1) begin failures++; $display("FAIL single_noic4_ready got %b want 1", cap_init[1]); end
    checks++;
    run_cmd(CMD_OCW1, 8'hFB);
    for (int c = 1; c <= 4; c++) begin
      if (cap_a0[c] !== 1'b1 || cap_dbo[c] !== 8'hFB || cap_oe[c] !== 1'b1 || cap_cs[c] !== 1'b0) begin
        failures++; $display("FAIL ocw1_bus cyc%0d got a0=%b dbo=%h oe=%b cs=%b want 1/fb/1/0", c, cap_a0[c], cap_dbo[c], cap_oe[c], cap_cs[c]);
      end
      checks++;
    end
  endtask

  task automatic test_read();
    run_cmd(CMD_OCW3, 8'h0A);
    if (cap_err[1] !== 1'b0 || cap_a0[1] !== 1'b0 || cap_wr[3] !== 1'b0) begin
      failures++; $display("FAIL ocw3 got err=%b a0=%b wr=%b want 0/0/0", cap_err[1], cap_a0[1], cap_wr[3]);
    end
    checks++;
    din = 8'h42;
    run_cmd(CMD_READ, 8'h00);
    for (int c = 1; c <= 5; c++) begin
      if (cap_rd[c] !== ((c == 2 || c == 3) ? 1'b0 : 1'b1) || cap_wr[c] !== 1'b1 || cap_oe[c] !== 1'b0) begin
        failures++; $display("FAIL read_strobe cyc%0d got rd=%b wr=%b oe=%b", c, cap_rd[c], cap_wr[c], cap_oe[c]);
      end
      checks++;
      if (cap_rv[c] !== (c == 4)) begin failures++; $display("FAIL read_rsp_valid cyc%0d got %b want %b", c, cap_rv[c], (c == 4)); end
      checks++;
    end
    if (cap_a0[2] !== 1'b0 || cap_rsp[4] !== 8'h42 || cap_rsp[5] !== 8'h42) begin
      failures++; $display("FAIL read_data got a0=%b rsp=%h/%h want 0/42/42", cap_a0[2], cap_rsp[4], cap_rsp[5]);
    end
    checks++;
    din = 8'h99;
    run_cmd(CMD_READ, 8'h01);
    if (cap_a0[2] !== 1'b1 || cap_rsp[1] !== 8'h42 || cap_rsp[4] !== 8'h99 || cap_rv[4] !== 1'b1) begin
      failures++; $display("FAIL read2 got a0=%b rsp1=%h rsp4=%h rv=%b want 1/42/99/1", cap_a0[2], cap_rsp[1], cap_rsp[4], cap_rv[4]);
    end
    checks++;
  endtask

  task automatic test_ocw2_and_reinit();
    run_cmd(CMD_OCW2, 8'h08);
    if (cap_err[1] !== 1'b1 || cap_cs[2] !== 1'b1) begin failures++; $display("FAIL ocw2_bad got err=%b cs=%b want 1/1", cap_err[1], cap_cs[2]); end
    checks++;
    run_cmd(CMD_OCW2, 8'h20);
    if (cap_err[1] !== 1'b0 || cap_cs[2] !== 1'b0 || cap_a0[2] !== 1'b0) begin
      failures++; $display("FAIL ocw2_good got err=%b cs=%b a0=%b want 0/0/0", cap_err[1], cap_cs[2], cap_a0[2]);
    end
    checks++;
    run_cmd(CMD_ICW1, 8'h11);
    if (cap_init[1] !== 1'b0 || cap_cs[1] !== 1'b0) begin failures++; $display("FAIL reinit got init=%b cs=%b want 0/0", cap_init[1], cap_cs[1]); end
    checks++;
    run_cmd(CMD_OCW1, 8'hFB);
    if (cap_err[1] !== 1'b1 || cap_cs[1] !== 1'b1) begin failures++; $display("FAIL reinit_ocw1 got err=%b cs=%b want 1/1", cap_err[1], cap_cs[1]); end
    checks++;
  endtask

  task automatic test_back_to_back_rejects();
    hif.cmd_kind = CMD_OCW1; hif.cmd_data = 8'h55; hif.cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (hif.cmd_error !== 1'b1 || hif.cmd_ready !== 1'b1 || chip_select_bar !== 1'b1) begin
        failures++; $display("FAIL b2b_reject cyc%0d got err=%b rdy=%b cs=%b want 1/1/1", i, hif.cmd_error, hif.cmd_ready, chip_select_bar);
      end
      checks++;
    end
    hif.cmd_valid = 1'b0;
    @(posedge clk); #1;
    if (hif.cmd_error !== 1'b0) begin failures++; $display("FAIL b2b_release got %b want 0", hif.cmd_error); end
    checks++;
  endtask

  task automatic test_reset_mid_strobe();
    hif.cmd_kind = CMD_ICW2; hif.cmd_data = 8'h20; hif.cmd_valid = 1'b1;
    @(posedge clk); #1; hif.cmd_valid = 1'b0;
    @(posedge clk); #1;
    if (write_bar !== 1'b0 || chip_select_bar !== 1'b0) begin
      failures++; $display("FAIL mid_pre got wr=%b cs=%b want 0/0", write_bar, chip_select_bar);
    end
    checks++;
    #2 reset = 1'b1;
    #1;
    if (write_bar !== 1'b1 || chip_select_bar !== 1'b1 || data_bus_oe !== 1'b0 || hif.cmd_ready !== 1'b1) begin
      failures++; $display("FAIL mid_reset got wr=%b cs=%b oe=%b rdy=%b want 1/1/0/1", write_bar, chip_select_bar, data_bus_oe, hif.cmd_ready);
    end
    checks++;
    @(posedge clk); #1; reset = 1'b0;
    @(posedge clk); #1;
    run_cmd(CMD_ICW2, 8'h20);
    if (cap_err[1] !== 1'b1 || cap_cs[1] !== 1'b1) begin failures++; $display("FAIL post_reset_icw2 got err=%b cs=%b want 1/1", cap_err[1], cap_cs[1]); end
    checks++;
    run_cmd(CMD_ICW1, 8'h11);
    if (cap_err[1] !== 1'b0 || cap_cs[1] !== 1'b0 || cap_wr[2] !== 1'b0) begin
      failures++; $display("FAIL post_reset_icw1 got err=%b cs=%b wr=%b want 0/0/0", cap_err[1], cap_cs[1], cap_wr[2]);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_init_sequence();
    test_sngl_skip();
    test_ocw1_gating();
    test_read();
    test_ocw2_and_reinit();
    test_back_to_back_rejects();
    test_reset_mid_strobe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pic_host_interface.md
# pic_host_interface

Synthesizable CPU-side bus initiator for the 8259A PIC core. It takes ICW/OCW/read commands over a valid/ready port and drives the PIC's `chip_select_bar`/`read_bar`/`write_bar`/`A0`/data-bus pins with programmable setup/strobe/hold timing. It enforces the ICW1→ICW2→(ICW3)→(ICW4) initialization order that the PIC's Read_Write_Logic decodes, and returns read data. It sits between a host controller and the PIC's bus pins, and is the other end of that bus.

## Interface
- `SETUP_CYCLES`, default 1: cycles with CS low and strobes high before strobe; minimum 1.
- `STROBE_CYCLES`, default 2: cycles with `write_bar`/`read_bar` low; minimum 1.
- `HOLD_CYCLES`, default 1: cycles with strobe high and CS/A0/data held after strobe; minimum 1.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  high only in bus state IDLE.
- `cmd_kind`  in  3  0 ICW1, 1 ICW2, 2 ICW3, 3 ICW4, 4 OCW1, 5 OCW2, 6 OCW3, 7 READ.
- `cmd_data`  in  8  write byte; for READ, bit0 is the A0 to use.
- `cmd_error`  out  1  one-cycle pulse when a command is rejected.
- `rsp_valid`  out  1  one-cycle pulse carrying read data; no backpressure.
- `rsp_data`  out  8  read byte; holds its value until the next read.
- `init_done`  out  1  high when the sequencer is in READY.
- `chip_select_bar`, `write_bar`, `read_bar`  out  1 each  PIC bus strobes, active-low.
- `A0`  out  1  PIC address bit.
- `data_bus_out`  out  8  byte driven to the PIC data bus.
- `data_bus_oe`  out  1  output enable for `data_bus_out`.
- `data_bus_in`  in  8  byte returned by the PIC data bus.

## Operation
- A command is accepted on the rising edge where `cmd_valid` and `cmd_ready` are both high.
- The accepted command is checked against the init sequencer:
  - UNINIT: only ICW1 is legal.
  - WAIT_ICW2 / WAIT_ICW3 / WAIT_ICW4: only the expected ICW, or ICW1, is legal.
  - READY: OCW1–3, READ and ICW1 are legal; ICW2–4 are illegal.
- Field checks, each an error if it fails:
  - ICW1 requires `cmd_data[4]`=1.
  - OCW2 requires `cmd_data[4:3]`=00.
  - OCW3 requires `cmd_data[4:3]`=01.
- On an illegal command: `cmd_error` pulses in the next cycle, no bus cycle is run, sequencer state is unchanged, and `cmd_ready` stays high.
- ICW1 always restarts the sequence. It latches IC4=`cmd_data[0]` and SNGL=`cmd_data[1]`, then moves to WAIT_ICW2.
- After ICW2: go to WAIT_ICW3 if SNGL=0; otherwise WAIT_ICW4 if IC4=1; otherwise READY.
- After ICW3: go to WAIT_ICW4 if IC4=1; otherwise READY.
- After ICW4: go to READY.
- The sequencer advances at acceptance, not at bus-cycle end.
- A0 mapping: ICW1/OCW2/OCW3 → 0; ICW2/ICW3/ICW4/OCW1 → 1; READ → `cmd_data[0]`.
- Bus FSM states: IDLE → SETUP (`SETUP_CYCLES`) → STROBE (`STROBE_CYCLES`) → HOLD (`HOLD_CYCLES`) → IDLE.
- `chip_select_bar`=0 in SETUP, STROBE and HOLD. `A0` is constant over the whole cycle.
- Writes:
  - `data_bus_out` = `cmd_data` and `data_bus_oe`=1 from SETUP through HOLD.
  - `write_bar`=0 in STROBE only.
- Reads:
  - `data_bus_oe`=0 throughout; `read_bar`=0 in STROBE only.
  - `data_bus_in` is sampled on the edge that ends the last STROBE cycle.
  - `rsp_valid`=1 with `rsp_data` in the first HOLD cycle.
- `write_bar` and `read_bar` are never low at the same time. All bus outputs are registered (glitch-free).

## Timing
- Reset values (asynchronous, immediate, including mid-cycle):
  - `chip_select_bar`/`write_bar`/`read_bar`=1, `A0`=0, `data_bus_out`=0, `data_bus_oe`=0.
  - `cmd_ready`=1, `cmd_error`=0, `rsp_valid`=0, `rsp_data`=0, `init_done`=0.
  - Sequencer UNINIT, bus FSM IDLE.
- Acceptance at edge E0 (T = SETUP_CYCLES + STROBE_CYCLES + HOLD_CYCLES):
  - Cycles E0+1 … E0+T are the bus cycle and `cmd_ready`=0.
  - Cycle E0+T+1 is IDLE with `cmd_ready`=1; the next acceptance is possible at that edge.
- `init_done` rises in the cycle after the completing ICW is accepted. It falls in the cycle after any ICW1 is accepted.
- Rejected command: `cmd_error` is high at E0+1 only; back-to-back rejects are allowed every cycle.
- Internal counters are sized with $clog2 of the largest phase parameter; each counter reloads on every phase entry.

## Structure
- Package `pic_pkg`: `cmd_kind` encoding constants, sequencer and bus-FSM state enums, and OCW2/OCW3 bit-check constants.
- Sub-module `pic_init_tracker`: sequencer plus legality and A0 decode. Outputs: `legal`, `a0`, `init_done`.
- Top level: bus FSM, phase counters, output registers, read capture.

## Test plan
- Reset, then ICW1 0x11, ICW2 0x20, ICW3 0x00, ICW4 0x01 (defaults 1/2/1) → four bus cycles with A0 sequence 0,1,1,1 and `write_bar` low for 2 cycles each. Each cycle is 4 cycles long with CS low; `init_done`=1 after the ICW4 acceptance.
- ICW1 0x13 (SNGL=1, IC4=1), then ICW2 0x08, then ICW3 → ICW3 rejected with a `cmd_error` pulse and no strobe; ICW4 0x01 then completes init.
- Before init: OCW1 0xFB → `cmd_error`, no CS activity. After init: OCW1 0xFB → A0=1, `data_bus_out`=0xFB.
- After init: OCW3 0x0A, then READ with `cmd_data`=0 and `data_bus_in`=0x42 during strobe → `read_bar` low 2 cycles, `data_bus_oe`=0, `rsp_valid` with `rsp_data`=0x42 in the first HOLD cycle.
- OCW2 0x08 (bits 4:3 = 01) → rejected. ICW1 issued in READY → `init_done` drops and OCW1 is then rejected.
- Assert `reset` during STROBE of a write → `write_bar`/`chip_select_bar` go high immediately, and a new command is accepted after release.
